// File: rtl/memory_access_controller_pkg.sv
// Shared types for the memory access controller: FSM state encoding and
// address alignment helper.
package memory_access_controller_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    REQ      = 2'b01,
    WAIT_RSP = 2'b10,
    DONE     = 2'b11
  } state_t;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;
  localparam int CNT_W  = 8;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/memory_access_controller.sv
// Bridges core load/store requests onto a valid/ready request channel and an
// unthrottled response channel, with a timeout that completes as a fault.
module memory_access_controller
  import memory_access_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memory_read,
  input  logic              memory_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  input  logic [MASK_W-1:0] write_mask,
  output logic [DATA_W-1:0] read_data,
  output logic              write_done,
  output logic              mem_stall,
  output logic              access_fault,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [MASK_W-1:0] bus_wmask,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rdata,
  output state_t            fsm_state
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] count;
  logic             fault_q;
  logic             latch_req;
  logic             load_rsp;
  logic             set_fault;
  logic             timeout_hit;

  // Request channel: a transfer happens on the rising edge where
  // bus_req_valid && bus_req_ready; valid and every bus_* field stay constant
  // from the first REQ cycle until that edge. Responses are never back-pressured.
  assign bus_req_valid = (state == REQ);
  assign timeout_hit   = (count >= TIMEOUT_LAST);
  assign mem_stall     = (memory_read | memory_write) && (state != DONE);
  assign write_done    = (state == DONE) && bus_we && !fault_q;
  assign access_fault  = (state == DONE) && fault_q;
  assign fsm_state     = state;

  always_comb begin
    next_state = state;
    latch_req  = 1'b0;
    load_rsp   = 1'b0;
    set_fault  = 1'b0;
    case (state)
      IDLE: begin
        if (memory_read || memory_write) begin
          latch_req  = 1'b1;
          next_state = REQ;
        end
      end
      REQ: begin
        if (bus_req_ready) begin
          next_state = WAIT_RSP;
        end else if (timeout_hit) begin
          set_fault  = 1'b1;
          next_state = DONE;
        end
      end
      WAIT_RSP: begin
        // A response on the expiry cycle still completes normally.
        if (bus_rsp_valid) begin
          load_rsp   = 1'b1;
          next_state = DONE;
        end else if (timeout_hit) begin
          set_fault  = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      read_data <= '0;
      fault_q   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wmask <= '0;
    end else begin
      state   <= next_state;
      fault_q <= set_fault;
      if (latch_req) begin
        // A simultaneous read and write request is treated as a write.
        bus_we    <= memory_write;
        bus_addr  <= word_align(address);
        bus_wdata <= write_data;
        bus_wmask <= write_mask;
        count     <= '0;
      end else if (state == REQ || state == WAIT_RSP) begin
        count <= count + CNT_W'(1);
      end
      if (load_rsp && !bus_we) begin
        read_data <= bus_rdata;
      end else if (set_fault) begin
        read_data <= '0;
      end
    end
  end

endmodule
